// File: rtl/chg_rec_queue.sv
// Change-record FIFO feeding myDesign's mydes_chgTxt_* inputs, with terminator detection.
// Optional build macro CHG_SKIP_ZERO_EN drops zero-valued (real==0, img==0) records on accept.
module chg_rec_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PTR_W    = 3,
    parameter logic [15:0] TERM_ROW = 16'hFFFF,
    parameter logic [15:0] TERM_COL = 16'hFFFF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_row,
    input  logic [15:0]      in_col,
    input  logic [23:0]      in_real,
    input  logic [23:0]      in_img,
    output logic             out_valid,
    input  logic             out_pop,
    output logic [15:0]      out_row,
    output logic [15:0]      out_col,
    output logic [23:0]      out_real,
    output logic [23:0]      out_img,
    output logic [PTR_W:0]   count,
    output logic             listDone
);

    logic [79:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             term_seen_q, term_seen_d;
    logic             list_done_q, list_done_d;
    logic [79:0]      last_q, last_d;

    logic        is_term, is_zero, push, store, pop;
    logic [79:0] head;

    assign is_term = (in_row == TERM_ROW) && (in_col == TERM_COL);
`ifdef CHG_SKIP_ZERO_EN
    assign is_zero = (in_real == 24'd0) && (in_img == 24'd0);
`else
    assign is_zero = 1'b0;
`endif

    assign in_ready  = (count_q != (PTR_W+1)'(DEPTH)) && !term_seen_q;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    // Terminator and (optionally) zero records complete the handshake but never occupy a slot.
    assign store     = push && !is_term && !is_zero;
    assign pop       = out_pop && out_valid;
    assign head      = mem_q[rptr_q];

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        term_seen_d = term_seen_q;
        last_d      = last_q;
        list_done_d = list_done_q | (term_seen_q && (count_q == '0));
        if (store) wptr_d = wptr_q + PTR_W'(1);
        if (pop)   rptr_d = rptr_q + PTR_W'(1);
        unique case ({store, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
        if (push && is_term) term_seen_d = 1'b1;
        // Remember the presented head so outputs hold their last value once drained.
        if (out_valid) last_d = head;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            term_seen_q <= 1'b0;
            list_done_q <= 1'b0;
            last_q      <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            term_seen_q <= term_seen_d;
            list_done_q <= list_done_d;
            last_q      <= last_d;
        end
    end

    always_ff @(posedge clock) begin
        if (store) mem_q[wptr_q] <= {in_row, in_col, in_real, in_img};
    end

    assign {out_row, out_col, out_real, out_img} = out_valid ? head : last_q;
    assign count    = count_q;
    assign listDone = list_done_q;

endmodule

// File: tb/tb_chg_rec_queue.sv
// Self-checking bench for chg_rec_queue: directed steps plus random traffic against a queue model.
module tb_chg_rec_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_row = '0;
    logic [15:0] in_col = '0;
    logic [23:0] in_real = '0;
    logic [23:0] in_img = '0;
    logic        out_valid;
    logic        out_pop = 1'b0;
    logic [15:0] out_row;
    logic [15:0] out_col;
    logic [23:0] out_real;
    logic [23:0] out_img;
    logic [3:0]  count;
    logic        listDone;

    chg_rec_queue dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_row   (in_row),
        .in_col   (in_col),
        .in_real  (in_real),
        .in_img   (in_img),
        .out_valid(out_valid),
        .out_pop  (out_pop),
        .out_row  (out_row),
        .out_col  (out_col),
        .out_real (out_real),
        .out_img  (out_img),
        .count    (count),
        .listDone (listDone)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Behavioural model: list of stored records, terminator flag, done flag, last head shown.
    logic [79:0] mq[$];
    logic        m_term;
    logic        m_done;
    logic [79:0] m_last;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_ready();
        return (mq.size() < 8) && !m_term;
    endfunction

    task automatic check_all(input string tag);
        logic [79:0] exp_head;
        exp_head = (mq.size() != 0) ? mq[0] : m_last;
        chk({tag, ".in_ready"}, 80'(in_ready), 80'(m_ready()));
        chk({tag, ".out_valid"}, 80'(out_valid), 80'(mq.size() != 0));
        chk({tag, ".count"}, 80'(count), 80'(mq.size()));
        chk({tag, ".listDone"}, 80'(listDone), 80'(m_done));
        chk({tag, ".head"}, {out_row, out_col, out_real, out_img}, exp_head);
        chk({tag, ".no_overflow"}, 80'(count <= 4'd8), 80'(1));
    endtask

    task automatic model_reset();
        mq.delete();
        m_term = 1'b0;
        m_done = 1'b0;
        m_last = '0;
    endtask

    // Drive one cycle, check pre-edge outputs, then advance the model across the edge.
    task automatic cycle(input string tag, input logic v, input logic [15:0] r, input logic [15:0] c,
                         input logic [23:0] re, input logic [23:0] im, input logic p);
        logic do_push, do_pop, set_done, skip;
        in_valid = v; in_row = r; in_col = c; in_real = re; in_img = im; out_pop = p;
        #1;
        check_all(tag);
        do_push  = v && m_ready();
        do_pop   = p && (mq.size() != 0);
        set_done = m_term && (mq.size() == 0);
`ifdef CHG_SKIP_ZERO_EN
        skip = (re == 24'd0) && (im == 24'd0);
`else
        skip = 1'b0;
`endif
        @(posedge clock);
        #1;
        if (mq.size() != 0) m_last = mq[0];
        if (set_done) m_done = 1'b1;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            if (r == 16'hFFFF && c == 16'hFFFF) m_term = 1'b1;
            else if (!skip) mq.push_back({r, c, re, im});
        end
    endtask

    task automatic push_rec(input string tag, input logic [15:0] r, input logic [15:0] c,
                            input logic [23:0] re, input logic [23:0] im);
        cycle(tag, 1'b1, r, c, re, im, 1'b0);
    endtask

    task automatic pop_rec(input string tag);
        cycle(tag, 1'b0, 16'h0, 16'h0, 24'h0, 24'h0, 1'b1);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 16'h0, 16'h0, 24'h0, 24'h0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0; in_valid = 1'b1; in_row = 16'h1234; out_pop = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b0; out_pop = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int guard;
        model_reset();
        @(posedge clock);
        #1;
        do_reset("reset");

        push_rec("first_push", 16'd3, 16'd5, 24'h000100, 24'h000200);
        chk("first_head", {out_row, out_col, out_real, out_img},
            {16'd3, 16'd5, 24'h000100, 24'h000200});
        pop_rec("first_pop");

        // Fill, overflow attempt, drain.
        for (int i = 0; i < 8; i++) push_rec("fill", 16'(i + 10), 16'(i), 24'(i + 1), 24'(i));
        chk("full_count", 80'(count), 80'(8));
        push_rec("overflow", 16'h77, 16'h77, 24'h7, 24'h7);
        chk("full_hold", 80'(count), 80'(8));
        for (int i = 0; i < 8; i++) pop_rec("drain");
        pop_rec("underflow");
        idle("empty");

        // Wrap: push 6, pop 4, push 5.
        for (int i = 0; i < 6; i++) push_rec("wrap_a", 16'(i + 40), 16'(i), 24'(i + 3), 24'h5);
        for (int i = 0; i < 4; i++) pop_rec("wrap_pop");
        for (int i = 0; i < 5; i++) push_rec("wrap_b", 16'(i + 60), 16'(i), 24'(i + 9), 24'h6);
        chk("wrap_count", 80'(count), 80'(7));
        for (int i = 0; i < 6; i++) pop_rec("wrap_drain");

        // Simultaneous push and pop at count 1.
        chk("sim_pre", 80'(count), 80'(1));
        cycle("sim_pp", 1'b1, 16'hAB, 16'hCD, 24'h11, 24'h22, 1'b1);
        chk("sim_count", 80'(count), 80'(1));
        chk("sim_row", 80'(out_row), 80'(16'hAB));
        pop_rec("sim_drain");

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [23:0] re, im;
            re = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
            im = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
            cycle("rand", 1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFE)),
                  16'($urandom), re, im, 1'($urandom_range(0, 2) != 0));
        end
        guard = 0;
        while (mq.size() != 0 && guard < 20) begin
            pop_rec("rand_drain");
            guard++;
        end
        chk("rand_drained", 80'(mq.size() == 0), 80'(1));

        // Terminator after two records, then pop both.
        push_rec("term_a", 16'd7, 16'd8, 24'h1, 24'h2);
        push_rec("term_b", 16'd9, 16'd10, 24'h3, 24'h4);
        push_rec("term", 16'hFFFF, 16'hFFFF, 24'h0, 24'h0);
        chk("term_ready", 80'(in_ready), 80'(0));
        pop_rec("term_pop1");
        pop_rec("term_pop2");
        chk("term_done_early", 80'(listDone), 80'(0));
        idle("term_wait");
        chk("term_done", 80'(listDone), 80'(1));
        push_rec("term_ignored", 16'd1, 16'd2, 24'h3, 24'h4);
        chk("term_ignored_count", 80'(count), 80'(0));

        // Reset mid-operation with records stored and terminator seen.
        do_reset("reset_mid_pre");
        for (int i = 0; i < 5; i++) push_rec("mid_fill", 16'(i + 1), 16'h2, 24'h5, 24'h6);
        push_rec("mid_term", 16'hFFFF, 16'hFFFF, 24'h0, 24'h0);
        chk("mid_count", 80'(count), 80'(5));
        do_reset("reset_mid");
        chk("mid_ready", 80'(in_ready), 80'(1));

        // Zero-valued record handling.
        push_rec("zero_a", 16'd1, 16'd1, 24'h0, 24'h0);
        push_rec("zero_b", 16'd2, 16'd2, 24'h1, 24'h0);
`ifdef CHG_SKIP_ZERO_EN
        chk("zero_count", 80'(count), 80'(1));
        chk("zero_head", 80'(out_row), 80'(2));
`else
        chk("zero_count", 80'(count), 80'(2));
        chk("zero_head", 80'(out_row), 80'(1));
`endif
        idle("zero_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
